// File: rtl/score_bcd_convert.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with saturation at MAX_SCORE.
// Optional registered 7-segment outputs when SCORE_SEG_EN is defined (needs NUM_DIGITS >= 3).
module score_bcd_convert #(
    parameter int IN_W       = 7,
    parameter int NUM_DIGITS = 3,
    parameter int MAX_SCORE  = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IN_W-1:0]           score_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic                      sat
`ifdef SCORE_SEG_EN
    ,
    output logic [6:0]                seg_hund,
    output logic [6:0]                seg_tens,
    output logic [6:0]                seg_ones
`endif
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0]  MAX_W    = IN_W'(MAX_SCORE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IN_W-1:0]    r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clamp;
    logic               w_clamp;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_sat;
    logic               r_done;

    assign w_clamp = (32'(score_in) > 32'(MAX_SCORE));
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign bcd_out = r_bcd_out;
    assign sat     = r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_CNT) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble before the shift; MAX_SCORE keeps the top nibble from carrying out.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

`ifdef SCORE_SEG_EN
    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [3:0] w_hund;
    logic [3:0] w_tens;
    assign w_hund = r_bcd[11:8];
    assign w_tens = r_bcd[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_hund <= 7'h7F;
            seg_tens <= 7'h7F;
            seg_ones <= 7'h7F;
        end else if (r_state == S_DONE) begin
            seg_hund <= (w_hund == 4'd0) ? 7'h7F : seg7(w_hund);
            seg_tens <= (w_hund == 4'd0 && w_tens == 4'd0) ? 7'h7F : seg7(w_tens);
            seg_ones <= seg7(r_bcd[3:0]);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_clamp   <= 1'b0;
            r_bcd_out <= '0;
            r_sat     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin   <= w_clamp ? MAX_W : score_in;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_clamp <= w_clamp;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[IN_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_bcd_out <= r_bcd;
                    r_sat     <= r_clamp;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_convert.sv
// Directed bench for score_bcd_convert: latency, saturation, retrigger, async reset abort.
// Define SCORE_SEG_EN for both files to also check the 7-segment outputs.
module tb_score_bcd_convert;

    localparam int IN_W = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  score_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        sat;
`ifdef SCORE_SEG_EN
    logic [6:0]  seg_hund;
    logic [6:0]  seg_tens;
    logic [6:0]  seg_ones;
`endif

    int n_checks = 0;
    int n_errors = 0;

    score_bcd_convert #(.IN_W(7), .NUM_DIGITS(3), .MAX_SCORE(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .score_in (score_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sat      (sat)
`ifdef SCORE_SEG_EN
        ,
        .seg_hund (seg_hund),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One conversion; retrig > 0 pulses start (score 20) that many cycles after the start edge.
    task automatic run_conv(input logic [6:0] val, input int retrig,
                            input logic [11:0] exp_bcd, input logic exp_sat, input string tag);
        int   lat     = -1;
        int   pulses  = 0;
        logic busy_ok = 1'b1;
        logic [11:0] bcd_at_done = '0;
        @(negedge clk);
        start    = 1'b1;
        score_in = val;
        @(negedge clk);
        start    = 1'b0;
        score_in = 7'($urandom_range(0, 127));
        if (!busy) busy_ok = 1'b0;
        for (int c = 1; c <= IN_W + 5; c++) begin
            if (retrig != 0 && c == retrig) begin
                start    = 1'b1;
                score_in = 7'd20;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat         = c;
                    bcd_at_done = bcd_out;
                end
            end
            if (lat < 0 && !busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, lat, IN_W + 1);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_busy"}, busy_ok, 1'b1);
        check({tag, "_bcd_at_done"}, bcd_at_done, exp_bcd);
        check({tag, "_bcd_hold"}, bcd_out, exp_bcd);
        check({tag, "_sat"}, sat, exp_sat);
    endtask

    initial begin
        int stray;
        rst      = 1'b1;
        start    = 1'b0;
        score_in = '0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 12'h000);
        check("rst_sat", sat, 1'b0);
`ifdef SCORE_SEG_EN
        check("rst_seg_hund", seg_hund, 7'h7F);
        check("rst_seg_tens", seg_tens, 7'h7F);
        check("rst_seg_ones", seg_ones, 7'h7F);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_conv(7'd0, 0, 12'h000, 1'b0, "zero");
`ifdef SCORE_SEG_EN
        check("seg0_hund", seg_hund, 7'h7F);
        check("seg0_tens", seg_tens, 7'h7F);
        check("seg0_ones", seg_ones, 7'h40);
`endif
        run_conv(7'd7, 0, 12'h007, 1'b0, "seven");
`ifdef SCORE_SEG_EN
        check("seg7_hund", seg_hund, 7'h7F);
        check("seg7_tens", seg_tens, 7'h7F);
        check("seg7_ones", seg_ones, 7'h78);
`endif
        run_conv(7'd50, 0, 12'h050, 1'b0, "fifty");
        run_conv(7'd99, 0, 12'h099, 1'b0, "ninety_nine");
        run_conv(7'd100, 0, 12'h100, 1'b0, "hundred");
        run_conv(7'd126, 0, 12'h100, 1'b1, "clamp126");
        run_conv(7'd10, 0, 12'h010, 1'b0, "ten");
        run_conv(7'd101, 0, 12'h100, 1'b1, "clamp101");
        run_conv(7'd127, 0, 12'h100, 1'b1, "clamp127");
        run_conv(7'd85, 3, 12'h085, 1'b0, "retrig85");

        // Abort a conversion of 42 with an asynchronous reset between clock edges.
        @(negedge clk);
        start    = 1'b1;
        score_in = 7'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bcd", bcd_out, 12'h000);
        check("abort_sat", sat, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        for (int c = 0; c < IN_W + 4; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("abort_no_activity", stray, 0);
        run_conv(7'd42, 0, 12'h042, 1'b0, "after_abort42");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
